// File: rtl/clock_gate_wakeup_ctrl.sv
// clock_gate_wakeup_ctrl: merges client clock requests into one wakeup level and grants clients once the gated clock has settled
module clock_gate_wakeup_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_SETTLE = 2,
  parameter int HOLD_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  aresetn,
  input  logic                  cfg_enable,
  input  logic [HOLD_WIDTH-1:0] cfg_hold_count,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  gating,
  output logic                  wakeup,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  clk_ready,
  output logic                  busy,
  output logic                  err_gate
);
  localparam int SW = $clog2(WAKE_SETTLE + 1);
  typedef enum logic [1:0] {IDLE, WAKING, ACTIVE, HOLD} state_t;
  state_t                state, state_nx;
  logic [SW-1:0]         settle, settle_nx;
  logic [HOLD_WIDTH-1:0] hold, hold_nx;
  logic                  any_req, settled;
  assign any_req = |req;
  assign settled = !gating && settle == SW'(WAKE_SETTLE - 1);
  always_comb begin
    state_nx  = state;
    settle_nx = settle;
    hold_nx   = hold;
    case (state)
      IDLE: if (any_req || !cfg_enable) begin
        state_nx  = WAKING;
        settle_nx = '0;
      end
      WAKING: begin
        settle_nx = gating ? '0 : settle + SW'(1);
        state_nx  = settled ? ACTIVE : WAKING;
      end
      ACTIVE: if (!any_req && cfg_enable) begin
        state_nx = HOLD;
        hold_nx  = cfg_hold_count;
      end
      HOLD: begin
        // a request arriving on the expiry edge wins; the clock never stopped, so no re-settle
        state_nx = (any_req || !cfg_enable) ? ACTIVE : (hold == '0) ? IDLE : HOLD;
        hold_nx  = (hold == '0) ? hold : hold - HOLD_WIDTH'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      settle    <= '0;
      hold      <= '0;
      wakeup    <= 1'b0;
      ack       <= '0;
      clk_ready <= 1'b0;
      busy      <= 1'b0;
      err_gate  <= 1'b0;
    end else begin
      state     <= state_nx;
      settle    <= settle_nx;
      hold      <= hold_nx;
      wakeup    <= state_nx != IDLE;
      busy      <= state_nx != IDLE;
      clk_ready <= state_nx == ACTIVE || state_nx == HOLD;
      ack       <= state_nx == ACTIVE ? req : '0;
      err_gate  <= err_gate | (gating && (state == ACTIVE || state == HOLD));
    end
  end
endmodule

// File: tb/tb_clock_gate_wakeup_ctrl.sv
// tb_clock_gate_wakeup_ctrl: directed and randomized checks against a cycle-level behavioural model
module tb_clock_gate_wakeup_ctrl;
  localparam int NR = 4;
  localparam int WS = 2;
  localparam int HW = 4;
  logic          clk_in = 1'b0;
  logic          aresetn;
  logic          cfg_enable;
  logic [HW-1:0] cfg_hold_count;
  logic [NR-1:0] req;
  logic          gating;
  logic          wakeup, clk_ready, busy, err_gate;
  logic [NR-1:0] ack;
  int checks = 0;
  int failures = 0;
  // model: clock requested, clock confirmed, idling after last request
  logic          m_awake, m_ready, m_hold, m_err;
  int            m_run, m_left;
  logic [NR-1:0] m_ack;
  clock_gate_wakeup_ctrl #(.NUM_REQ(NR), .WAKE_SETTLE(WS), .HOLD_WIDTH(HW)) dut (
    .clk_in(clk_in), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_hold_count(cfg_hold_count),
    .req(req), .gating(gating), .wakeup(wakeup), .ack(ack), .clk_ready(clk_ready), .busy(busy),
    .err_gate(err_gate)
  );
  always #5 clk_in = ~clk_in;
  wire [NR+3:0] dut_vec = {wakeup, busy, clk_ready, err_gate, ack};
  function automatic logic [NR+3:0] exp_vec();
    return {m_awake, m_awake, m_ready, m_err, m_ack};
  endfunction
  task automatic model_reset();
    m_awake = 0; m_ready = 0; m_hold = 0; m_err = 0; m_run = 0; m_left = 0; m_ack = '0;
  endtask
  task automatic model_edge();
    m_err = m_err | (gating & m_ready);
    if (!m_awake) begin
      if (|req || !cfg_enable) begin m_awake = 1; m_run = 0; end
    end else if (!m_ready) begin
      m_run = gating ? 0 : m_run + 1;
      if (m_run == WS) begin m_ready = 1; m_hold = 0; end
    end else if (m_hold) begin
      if (|req || !cfg_enable) m_hold = 0;
      else if (m_left == 0) begin m_awake = 0; m_ready = 0; m_hold = 0; end
      else m_left--;
    end else if (!(|req) && cfg_enable) begin
      m_hold = 1; m_left = int'(cfg_hold_count);
    end
    m_ack = (m_ready && !m_hold) ? req : '0;
  endtask
  task automatic step(input logic [NR-1:0] r, input logic g);
    req = r; gating = g;
    model_edge();
    @(posedge clk_in); #1;
  endtask
  task automatic apply_reset();
    aresetn = 0; req = '0; gating = 1; cfg_enable = 1; cfg_hold_count = 4'd3;
    model_reset();
    repeat (2) @(negedge clk_in);
    aresetn = 1;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL reset outputs got=%b want=%b", dut_vec, {(NR+4){1'b0}}); end
    step('0, 1);
    checks++;
    if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_idle got=%b want=%b", dut_vec, exp_vec()); end
  endtask
  task automatic test_cold_wake_and_hold();
    cfg_hold_count = 4'd3;
    step(4'b0001, 1);
    checks++;
    if (wakeup !== 1'b1 || ack !== 4'b0000) begin failures++; $display("FAIL cold_wake_edge0 wakeup=%b ack=%b want 1/0000", wakeup, ack); end
    step(4'b0001, 0);
    checks++;
    if (ack !== 4'b0000 || dut_vec !== exp_vec()) begin failures++; $display("FAIL cold_wake_edge1 got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0001, 0);
    checks++;
    if (ack !== 4'b0001 || dut_vec !== exp_vec()) begin failures++; $display("FAIL cold_wake_ack got=%b want=%b", dut_vec, exp_vec()); end
    repeat (3) step(4'b0001, 0);
    step(4'b0000, 0);
    checks++;
    if (ack !== 4'b0000 || wakeup !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL hold_entry got=%b want=%b", dut_vec, exp_vec()); end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 0);
      checks++;
      if (wakeup !== 1'b1 || dut_vec !== exp_vec()) begin failures++; $display("FAIL hold_cycle%0d got=%b want=%b", i, dut_vec, exp_vec()); end
    end
    step(4'b0000, 0);
    checks++;
    if (wakeup !== 1'b0 || busy !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL hold_expiry got=%b want=%b", dut_vec, exp_vec()); end
  endtask
  task automatic test_rerequest_in_hold();
    step(4'b0010, 1);
    repeat (WS) step(4'b0010, 0);
    step(4'b0000, 0);
    step(4'b0000, 0);
    step(4'b0010, 0);
    checks++;
    if (ack !== 4'b0010 || busy !== 1'b1 || dut_vec !== exp_vec()) begin failures++; $display("FAIL rerequest_hold got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0000, 0);
    step(4'b0010, 0);
    checks++;
    if (ack !== 4'b0010 || dut_vec !== exp_vec()) begin failures++; $display("FAIL rerequest_again got=%b want=%b", dut_vec, exp_vec()); end
  endtask
  task automatic test_hold_zero();
    cfg_hold_count = 4'd0;
    step(4'b0000, 0);
    checks++;
    if (clk_ready !== 1'b1 || ack !== 4'b0000) begin failures++; $display("FAIL hold_zero_entry got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0000, 0);
    checks++;
    if (wakeup !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL hold_zero_exit got=%b want=%b", dut_vec, exp_vec()); end
    cfg_hold_count = 4'd3;
  endtask
  task automatic test_settle_restart();
    step(4'b0100, 1);
    step(4'b0100, 0);
    step(4'b0100, 1);
    step(4'b0100, 0);
    checks++;
    if (ack !== 4'b0000 || dut_vec !== exp_vec()) begin failures++; $display("FAIL settle_restart_early got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0100, 0);
    checks++;
    if (ack !== 4'b0100 || err_gate !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL settle_restart_ack got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0000, 0);
    repeat (5) step(4'b0000, 0);
    checks++;
    if (dut_vec !== exp_vec() || wakeup !== 1'b0) begin failures++; $display("FAIL settle_restart_idle got=%b want=%b", dut_vec, exp_vec()); end
  endtask
  task automatic test_bypass();
    apply_reset();
    cfg_enable = 0;
    step(4'b0000, 1);
    checks++;
    if (wakeup !== 1'b1 || clk_ready !== 1'b0) begin failures++; $display("FAIL bypass_wake got=%b want=%b", dut_vec, exp_vec()); end
    repeat (WS) step(4'b0000, 0);
    checks++;
    if (clk_ready !== 1'b1 || ack !== 4'b0000 || dut_vec !== exp_vec()) begin failures++; $display("FAIL bypass_active got=%b want=%b", dut_vec, exp_vec()); end
    for (int i = 0; i < 5; i++) begin
      step((i < 3) ? 4'b1000 : 4'b0000, 0);
      checks++;
      if (ack[3] !== (i < 3) || clk_ready !== 1'b1 || dut_vec !== exp_vec()) begin failures++; $display("FAIL bypass_pulse%0d got=%b want=%b", i, dut_vec, exp_vec()); end
    end
    cfg_enable = 1;
    cfg_hold_count = 4'd2;
    step(4'b0000, 0);
    repeat (2) step(4'b0000, 0);
    checks++;
    if (wakeup !== 1'b1 || dut_vec !== exp_vec()) begin failures++; $display("FAIL bypass_to_hold got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0000, 0);
    checks++;
    if (wakeup !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL bypass_hold_done got=%b want=%b", dut_vec, exp_vec()); end
    cfg_hold_count = 4'd3;
  endtask
  task automatic test_err_and_reset();
    step(4'b0001, 1);
    repeat (WS) step(4'b0001, 0);
    step(4'b0001, 1);
    checks++;
    if (err_gate !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0000, 0);
    step(4'b0000, 0);
    checks++;
    if (err_gate !== 1'b1 || dut_vec !== exp_vec()) begin failures++; $display("FAIL err_sticky got=%b want=%b", dut_vec, exp_vec()); end
    #2 aresetn = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL async_reset got=%b want=%b", dut_vec, {(NR+4){1'b0}}); end
    @(negedge clk_in);
    aresetn = 1;
    step(4'b0001, 0);
    step(4'b0001, 0);
    checks++;
    if (ack !== 4'b0000 || dut_vec !== exp_vec()) begin failures++; $display("FAIL post_reset_settle got=%b want=%b", dut_vec, exp_vec()); end
    step(4'b0001, 0);
    checks++;
    if (ack !== 4'b0001 || err_gate !== 1'b0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL post_reset_ack got=%b want=%b", dut_vec, exp_vec()); end
  endtask
  task automatic test_random();
    logic [NR-1:0] r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
      if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 15) == 0) cfg_hold_count = HW'($urandom_range(0, 5));
      step(r, $urandom_range(0, 4) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random cycle=%0d got=%b want=%b", i, dut_vec, exp_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_cold_wake_and_hold();
    test_rerequest_in_hold();
    test_hold_zero();
    test_settle_restart();
    test_bypass();
    test_err_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_gate_wakeup_ctrl.md
Name: clock_gate_wakeup_ctrl

Overview:
- Requester-side companion to clock_gate_ctrl. It runs in the ungated domain and merges NUM_REQ clock-request handshakes from gated-domain clients into the single wakeup level that drives clock_gate_ctrl.
- It monitors the returned gating indicator and grants each client only after the gated clock has been confirmed running for WAKE_SETTLE cycles.
- After the last request drops, it keeps wakeup high for a programmable hold time so that short request gaps do not cause gate/ungate thrash.

Parameters:
- NUM_REQ, 4: number of requesting clients; range 1-16.
- WAKE_SETTLE, 2: consecutive cycles with gating=0 required before any ack; range 1-15.
- HOLD_WIDTH, 4: width of the hold-off counter.

Ports:
- clk_in  input  1  ungated clock; the same clock that feeds clock_gate_ctrl.
- aresetn  input  1  reset; asynchronous, active-low.
- cfg_enable  input  1  1 = normal gating handshake; 0 = bypass, clock forced on.
- cfg_hold_count  input  HOLD_WIDTH  idle cycles after the last request before wakeup is released.
- req  input  NUM_REQ  per-client clock request, level.
- gating  input  1  gating indicator from clock_gate_ctrl (1 = clock gated).
- wakeup  output  1  to the clock_gate_ctrl wakeup input; registered.
- ack  output  NUM_REQ  per-client grant, registered; 1 = gated clock guaranteed running.
- clk_ready  output  1  1 in ACTIVE or HOLD.
- busy  output  1  1 whenever state != IDLE.
- err_gate  output  1  sticky flag: gating was seen high while clk_ready=1.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - state=IDLE.
  - wakeup, ack, clk_ready, busy, err_gate all 0.
  - Settle counter 0; hold counter 0.
- States: IDLE, WAKING, ACTIVE, HOLD. All outputs are registered and decoded from the next state.
- IDLE:
  - wakeup=0.
  - |req=1 or cfg_enable=0 -> WAKING; wakeup=1 from that edge; settle counter cleared.
- WAKING:
  - wakeup=1, ack=0.
  - Settle counter increments each cycle gating=0 and clears to 0 on any cycle gating=1.
  - Exit to ACTIVE when gating=0 and counter==WAKE_SETTLE-1; on that edge ack <= req.
  - If all req drop while WAKING (cfg_enable=1), stay in WAKING until settled, then take the normal ACTIVE->HOLD path. WAKING is never aborted.
- ACTIVE:
  - wakeup=1; ack <= req every cycle, so an ack falls one edge after its req falls.
  - A new req is acked on the next edge.
  - |req=0 and cfg_enable=1 -> HOLD; hold counter <= cfg_hold_count; ack <= 0.
- HOLD:
  - wakeup=1, ack=0.
  - |req=1 -> ACTIVE with ack <= req on that same edge. No re-settle, because the clock never stopped.
  - Otherwise the hold counter decrements, saturating at 0.
  - Counter==0 with no req -> IDLE; wakeup=0 from that edge.
  - cfg_hold_count=0 -> exactly one HOLD cycle.
- cfg_enable=0:
  - The FSM reaches or stays in ACTIVE via the normal path and never enters HOLD; ack mirrors req with 1-cycle latency.
  - cfg_enable returning to 1 with no req -> HOLD with a fresh load of cfg_hold_count.
- Simultaneous events:
  - A req rising on the same edge the hold counter hits 0 wins: go to ACTIVE, not IDLE.
  - A req rising on the same edge as the IDLE transition is seen next cycle and restarts WAKING.
- Latency: req sampled high at edge E in IDLE with gating responding combinationally gives wakeup at E and ack at E+WAKE_SETTLE.
- err_gate:
  - Set when gating=1 while state is ACTIVE or HOLD.
  - Cleared only by reset.
  - The FSM continues unaffected.
- Reset mid-operation: all outputs drop asynchronously. After release, the FSM starts from IDLE and re-settles before any ack.
- Widths: the settle counter is $clog2(WAKE_SETTLE+1) bits. Counters never wrap.

Test Plan:
- Cold wake, WAKE_SETTLE=2, cfg_hold_count=3, DUT chained to clock_gate_ctrl (idle=2), req[0] rises at edge 10 -> wakeup=1 after edge 10, ack[0]=1 after edge 12, gating=0 throughout.
- Hold expiry: req[0] falls at edge 20 -> ack[0]=0 after edge 20; HOLD 20-23; wakeup=0 after edge 24; clock_gate_ctrl gating=1 three edges later.
- Re-request in HOLD: req[1] rises at edge 22 -> ack[1]=1 after edge 22 with no settle cycles, busy stays 1, no gating pulse.
- Settle restart: force gating=1 in the 2nd WAKING cycle -> counter clears; ack arrives 2 cycles after gating returns to 0; err_gate stays 0.
- Bypass: cfg_enable=0 from reset with req=0 -> wakeup=1 and ACTIVE after 2 cycles; req[3] pulse of 3 cycles -> ack[3] high 3 cycles, delayed 1 cycle; no HOLD entry.
- Abuse/reset: drive gating=1 in ACTIVE -> err_gate=1 sticky; assert aresetn=0 mid-HOLD -> all outputs 0 immediately; after release, req[0] is re-acked only after WAKE_SETTLE cycles.
